// File: rtl/mux_rr_stream.sv
// N-channel streaming selector with round-robin or fixed-priority arbitration and one output register.
// Latency: one edge from input transfer to out_valid. Backpressure: out_ready low holds the word and drops every in_ready.
module mux_rr_stream #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = 0,
  localparam int CHW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [CHW-1:0]            out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHW-1:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic                vld_q, vld_d;

  logic [CHANNELS-1:0] grant;
  logic [CHW-1:0]      grant_idx;
  logic                grant_vld;
  logic [WIDTH-1:0]    grant_data;
  logic [CHW-1:0]      start;
  logic [CHW:0]        cand;
  logic                load_en;
  logic                xfer;

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign load_en = (~vld_q | out_ready) & rst_n;
  assign start   = (MODE == 1) ? '0 : ptr_q;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      cand = {1'b0, start} + (CHW+1)'(j);
      if (cand >= (CHW+1)'(CHANNELS)) begin
        cand = cand - (CHW+1)'(CHANNELS);
      end
      if (!grant_vld && in_valid[cand[CHW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CHW-1:0];
      end
    end
    grant[grant_idx] = grant_vld;
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant[k]) begin
        grant_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer     = grant_vld & load_en;
  assign in_ready = grant & {CHANNELS{load_en}};

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      data_d = grant_data;
      ch_d   = grant_idx;
      vld_d  = 1'b1;
      if (MODE == 0) begin
        ptr_d = (grant_idx == CHW'(CHANNELS-1)) ? '0 : grant_idx + CHW'(1);
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_valid = vld_q;

endmodule
